alu_hilo: RTL and testbench
===========================

ALU_HILO -- requirements
Module: alu_hilo

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset: clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 valid  input  1  EX-stage instruction present this cycle.
REQ-005 ALUOperation  input  6  operation code equal to MIPS funct: add=32, sub=34, and=36, or=37, slt=42, multu=25, mfhi=16, mflo=18.
REQ-006 A  input  32  operand rs.
REQ-007 B  input  32  operand rt.
REQ-008 Result  output  32  combinational result.
REQ-009 Zero  output  1  high when Result == 0.
REQ-010 Stall  output  1  combinational; the pipeline holds EX and earlier stages while it is high.
REQ-011 Busy  output  1  registered; high while a multu is in progress.
REQ-012 Done  output  1  registered; one-cycle pulse after HI/LO are written.

Function
REQ-013 add/sub SHALL be 32-bit modulo; overflow is ignored and the sum wraps.
REQ-014 and/or SHALL be bitwise.
REQ-015 slt SHALL be a signed compare and return 32'd1 or 32'd0.
REQ-016 mfhi SHALL return HI and mflo SHALL return LO.
REQ-017 multu and any undefined code SHALL return Result = 0.
REQ-018 Result SHALL be combinational regardless of valid.
REQ-019 Acceptance: multu is accepted on an edge where valid=1, ALUOperation=25 and Busy=0; A and B are latched at that edge.
REQ-020 Iterative mode: a 6-bit counter loads 32 at acceptance, and Busy rises at the same edge.
  - Each subsequent edge performs one unsigned shift-add step and decrements the counter.
  - At the 32nd step edge, {HI,LO} receives the 64-bit product and Busy falls.
  - Busy is therefore high for exactly 32 cycles.
REQ-021 Done SHALL be high for exactly the one cycle following the HI/LO write edge.
REQ-022 Stall = Busy & valid & (ALUOperation is multu, mfhi or mflo).
  - Other operations are not stalled and execute normally during Busy.
REQ-023 A multu or mfhi/mflo stalled by REQ-022 SHALL proceed unchanged on the first cycle Busy=0.
  - mfhi/mflo then observe the new product.
REQ-024 Back-to-back: a multu presented in the Done cycle SHALL be accepted in that cycle.
REQ-025 HI/LO SHALL change only on product write or reset; mfhi/mflo outside Busy return the last product.
REQ-026 Operand inputs changing during Busy SHALL NOT affect the product in progress.

Reset
REQ-027 While rst=1: HI=0, LO=0, Busy=0, Done=0, counter=0, and the latched operands are 0.
REQ-028 Reset asserted mid-multiply SHALL abort the operation; no HI/LO write and no Done pulse occur.
REQ-029 After rst deasserts, the first edge with a valid multu SHALL be accepted.

Configuration
REQ-030 The macro ALU_HILO_FAST_MULTU_EN SHALL select the multiplier implementation.
  - Defined: {HI,LO} = A*B is written at the acceptance edge; Busy never asserts; Stall is constant 0; Done pulses the following cycle.
  - Undefined: the 32-cycle iterative behaviour of REQ-020..REQ-024 applies.
  - All combinational operations are identical in both builds.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
  - add A=32'hFFFFFFFF, B=1 -> Result=0, Zero=1.
  - slt A=32'hFFFFFFFE (-2), B=1 -> Result=1.
  - sub A=5, B=7 -> Result=32'hFFFFFFFE, Zero=0.
  - multu A=32'hFFFFFFFF, B=32'hFFFFFFFF, then mfhi held valid:
    - Iterative build: Stall high for 32 cycles, then Done pulses, HI=32'hFFFFFFFE and LO=32'h00000001.
    - Fast build: no stall, and mfhi returns 32'hFFFFFFFE on the next cycle.
  - multu 3*4, then add 2+2 during Busy -> the add returns 4 with Stall=0; the following mflo (after Busy falls) returns 12.
  - multu 7*9 with rst pulsed at Busy cycle 10 -> Busy=0, HI=LO=0, no Done.
    - A subsequent multu 7*9 yields LO=63 after 32 cycles.

Source files
------------

// File: rtl/alu_hilo_if.sv
// EX-stage ALU bus: operation/operands in, result and HI/LO multiply status out.
interface alu_hilo_if;
  logic        valid;
  logic [5:0]  ALUOperation;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Result;
  logic        Zero;
  logic        Stall;
  logic        Busy;
  logic        Done;

  modport master (
    output valid, ALUOperation, A, B,
    input  Result, Zero, Stall, Busy, Done
  );

  modport slave (
    input  valid, ALUOperation, A, B,
    output Result, Zero, Stall, Busy, Done
  );
endinterface

// File: rtl/alu_hilo.sv
// MIPS EX-stage ALU with HI/LO multu. ALU_HILO_FAST_MULTU_EN selects a single-cycle
// multiplier; otherwise a 32-step shift-add multiplier holds Busy for 32 cycles.
module alu_hilo (
  input  logic      clk,
  input  logic      rst,
  alu_hilo_if.slave bus
);
  localparam logic [5:0] OpAdd   = 6'd32;
  localparam logic [5:0] OpSub   = 6'd34;
  localparam logic [5:0] OpAnd   = 6'd36;
  localparam logic [5:0] OpOr    = 6'd37;
  localparam logic [5:0] OpSlt   = 6'd42;
  localparam logic [5:0] OpMultu = 6'd25;
  localparam logic [5:0] OpMfhi  = 6'd16;
  localparam logic [5:0] OpMflo  = 6'd18;

  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        done_q;
  logic        is_multu;
  logic [31:0] result;

  assign is_multu = bus.valid && (bus.ALUOperation == OpMultu);

  always_comb begin
    result = '0;
    case (bus.ALUOperation)
      OpAdd:   result = bus.A + bus.B;
      OpSub:   result = bus.A - bus.B;
      OpAnd:   result = bus.A & bus.B;
      OpOr:    result = bus.A | bus.B;
      OpSlt:   result = {31'b0, $signed(bus.A) < $signed(bus.B)};
      OpMfhi:  result = hi_q;
      OpMflo:  result = lo_q;
      default: result = '0;
    endcase
  end

  assign bus.Result = result;
  assign bus.Zero   = (result == '0);
  assign bus.Done   = done_q;

`ifdef ALU_HILO_FAST_MULTU_EN
  logic [63:0] product;

  assign product = 64'(bus.A) * 64'(bus.B);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= is_multu;
      if (is_multu) begin
        {hi_q, lo_q} <= product;
      end
    end
  end

  assign bus.Busy  = 1'b0;
  assign bus.Stall = 1'b0;
`else
  logic        busy_q;
  logic [5:0]  cnt_q;
  logic [31:0] a_q;
  logic [63:0] p_q;
  logic [32:0] sum;
  logic [63:0] p_step;

  // p_q = {partial product, remaining multiplier bits}; the carry out of the
  // add is shifted back in so no product bit is lost.
  assign sum    = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, a_q} : 33'd0);
  assign p_step = {sum, p_q[31:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
      a_q    <= '0;
      p_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (busy_q) begin
        p_q   <= p_step;
        cnt_q <= cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          {hi_q, lo_q} <= p_step;
          busy_q       <= 1'b0;
          done_q       <= 1'b1;
        end
      end else if (is_multu) begin
        a_q    <= bus.A;
        p_q    <= {32'b0, bus.B};
        cnt_q  <= 6'd32;
        busy_q <= 1'b1;
      end
    end
  end

  assign bus.Busy  = busy_q;
  assign bus.Stall = busy_q && bus.valid &&
                     ((bus.ALUOperation == OpMultu) || (bus.ALUOperation == OpMfhi) ||
                      (bus.ALUOperation == OpMflo));
`endif
endmodule

// File: tb/tb_alu_hilo.sv
// Bench for alu_hilo: cycle-level countdown model compared every cycle, plus directed
// literal checks. Honours ALU_HILO_FAST_MULTU_EN the same way as the design.
module tb_alu_hilo;
  localparam logic [5:0] OpAdd   = 6'd32;
  localparam logic [5:0] OpSub   = 6'd34;
  localparam logic [5:0] OpAnd   = 6'd36;
  localparam logic [5:0] OpOr    = 6'd37;
  localparam logic [5:0] OpSlt   = 6'd42;
  localparam logic [5:0] OpMultu = 6'd25;
  localparam logic [5:0] OpMfhi  = 6'd16;
  localparam logic [5:0] OpMflo  = 6'd18;

`ifdef ALU_HILO_FAST_MULTU_EN
  localparam int ExpStall = 0;
  localparam logic ExpBusyDuring = 1'b0;
`else
  localparam int ExpStall = 32;
  localparam logic ExpBusyDuring = 1'b1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  bit   cmp_on = 1'b0;

  alu_hilo_if bus ();

  alu_hilo dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: HI/LO, cycles of Busy left, pending product, Done flag.
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] m_pend = '0;
  int          m_left = 0;
  bit          m_done = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hi = '0; m_lo = '0; m_pend = '0; m_left = 0; m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      m_done = (m_left == 0);
      if (m_left == 0) {m_hi, m_lo} = m_pend;
    end else begin
      m_done = 1'b0;
      if (bus.valid && bus.ALUOperation == OpMultu) begin
`ifdef ALU_HILO_FAST_MULTU_EN
        {m_hi, m_lo} = {32'b0, bus.A} * {32'b0, bus.B};
        m_done = 1'b1;
`else
        m_pend = {32'b0, bus.A} * {32'b0, bus.B};
        m_left = 32;
`endif
      end
    end
  end

  function automatic logic [31:0] exp_result(input logic [5:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    case (op)
      OpAdd:   return a + b;
      OpSub:   return a - b;
      OpAnd:   return a & b;
      OpOr:    return a | b;
      OpSlt:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OpMfhi:  return m_hi;
      OpMflo:  return m_lo;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      logic [31:0] er;
      logic        eb;
      er = exp_result(bus.ALUOperation, bus.A, bus.B);
      eb = (m_left > 0);
      chk("cmp_result", bus.Result, er);
      chk("cmp_zero", 32'(bus.Zero), 32'(er == 0));
      chk("cmp_busy", 32'(bus.Busy), 32'(eb));
      chk("cmp_done", 32'(bus.Done), 32'(m_done));
      chk("cmp_stall", 32'(bus.Stall), 32'(eb && bus.valid && (bus.ALUOperation == OpMultu ||
          bus.ALUOperation == OpMfhi || bus.ALUOperation == OpMflo)));
    end
  end

  task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    @(posedge clk);
    #2;
    bus.valid = v; bus.ALUOperation = op; bus.A = a; bus.B = b;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_no_stall(output int n);
    n = 0;
    settle();
    while (bus.Stall && n < 100) begin
      n++;
      settle();
    end
    if (n >= 100) chk("stall_timeout", 32'(n), 32'(ExpStall));
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[7] = '{
    '{OpAdd, 32'hFFFFFFFF, 32'h1,        32'h0},
    '{OpSlt, 32'hFFFFFFFE, 32'h1,        32'h1},
    '{OpSlt, 32'h1,        32'hFFFFFFFE, 32'h0},
    '{OpSub, 32'h5,        32'h7,        32'hFFFFFFFE},
    '{OpAnd, 32'hF0F0,     32'hFF00,     32'hF000},
    '{OpOr,  32'hF0F0,     32'hFF00,     32'hFFF0},
    '{6'd0,  32'h1234,     32'h5678,     32'h0}
  };

  initial begin
    int n;
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.valid = 1'b1; bus.ALUOperation = OpMfhi; bus.A = '0; bus.B = '0;
    @(posedge clk);
    cmp_on = 1'b1;
    settle();
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_done", 32'(bus.Done), 32'd0);
    chk("rst_hi", bus.Result, 32'd0);
    chk("rst_zero", 32'(bus.Zero), 32'd1);
    @(posedge clk);
    #2 rst = 1'b0;

    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      settle();
      chk("vec_result", bus.Result, vecs[i].r);
      chk("vec_zero", 32'(bus.Zero), 32'(vecs[i].r == 0));
    end

    // multu max*max, then mfhi held
    drive(1'b1, OpMultu, 32'hFFFFFFFF, 32'hFFFFFFFF);
    drive(1'b1, OpMfhi, '0, '0);
    wait_no_stall(n);
    chk("max_stall_cycles", 32'(n), 32'(ExpStall));
    chk("max_done", 32'(bus.Done), 32'd1);
    chk("max_hi", bus.Result, 32'hFFFFFFFE);
    drive(1'b1, OpMflo, '0, '0);
    settle();
    chk("max_lo", bus.Result, 32'h00000001);

    // Non-HI/LO ops run during Busy
    drive(1'b1, OpMultu, 32'd3, 32'd4);
    drive(1'b1, OpAdd, 32'd2, 32'd2);
    settle();
    chk("busy_add", bus.Result, 32'd4);
    chk("busy_add_stall", 32'(bus.Stall), 32'd0);
    chk("busy_add_busy", 32'(bus.Busy), 32'(ExpBusyDuring));
    drive(1'b1, OpMflo, '0, '0);
    wait_no_stall(n);
    chk("mflo_12", bus.Result, 32'd12);

    // Back-to-back: second multu accepted in the Done cycle
    drive(1'b1, OpMultu, 32'd5, 32'd6);
    drive(1'b1, OpMultu, 32'd10, 32'd10);
    wait_no_stall(n);
    chk("b2b_done", 32'(bus.Done), 32'd1);
    drive(1'b0, OpAdd, '0, '0);
    n = 0;
    settle();
    while (!bus.Done && n < 100) begin
      n++;
      settle();
    end
    chk("b2b_wait", 32'(n < 100), 32'd1);
    drive(1'b1, OpMflo, '0, '0);
    settle();
    chk("b2b_lo", bus.Result, 32'd100);

    // Reset during Busy cycle 10 aborts the multiply
    drive(1'b1, OpMultu, 32'd7, 32'd9);
    for (int i = 0; i < 9; i++) drive(1'b0, OpAdd, $urandom, $urandom);
    @(posedge clk);
    #2 rst = 1'b1;
    settle();
    chk("abort_busy", 32'(bus.Busy), 32'd0);
    chk("abort_done", 32'(bus.Done), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    bus.valid = 1'b1; bus.ALUOperation = OpMfhi;
    settle();
    chk("abort_hi", bus.Result, 32'd0);
    chk("abort_done2", 32'(bus.Done), 32'd0);
    drive(1'b1, OpMflo, '0, '0);
    settle();
    chk("abort_lo", bus.Result, 32'd0);

    // Fresh multu; operands churn while it runs
    drive(1'b1, OpMultu, 32'd7, 32'd9);
    n = 0;
    do begin
      drive(1'b1, OpAdd, $urandom, $urandom);
      settle();
      n++;
    end while (!bus.Done && n < 100);
    chk("redo_cycles", 32'(n), 32'(ExpStall + 1));
    drive(1'b1, OpMflo, 32'hDEAD, 32'hBEEF);
    settle();
    chk("redo_lo", bus.Result, 32'd63);
    drive(1'b1, OpMfhi, '0, '0);
    settle();
    chk("redo_hi", bus.Result, 32'd0);

    drive(1'b0, OpAdd, '0, '0);
    settle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
